// File: rtl/arm_regfile_sb.sv
// ---------------------------------------------------------------------------
// arm_regfile_sb -- ARM pipeline register file with a pending-write
// scoreboard and a sequenced clear engine.
//
// Optional feature: define RF_WB_BYPASS_EN to forward same-cycle write data
// to the read ports (port 0 data before port 1 data).
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   src1, src2               read indices
//   reg1, reg2               read data (combinational)
//   busy1, busy2             pending bit of src1 / src2
//   writeBackEn/Dest_wb/Result_WB   write port 0 (write-back result)
//   wr2_en/wr2_addr/wr2_data        write port 1 (base-register update)
//   issue_en/issue_dest      mark a register as awaiting a result
//   clr_req                  start the clear sequence
//   clr_busy                 clear sequence in progress
// ---------------------------------------------------------------------------
module arm_regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] src1,
    input  logic [ADDR_W-1:0] src2,
    input  logic              writeBackEn,
    input  logic [ADDR_W-1:0] Dest_wb,
    input  logic [DATA_W-1:0] Result_WB,
    input  logic              wr2_en,
    input  logic [ADDR_W-1:0] wr2_addr,
    input  logic [DATA_W-1:0] wr2_data,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_dest,
    input  logic              clr_req,
    output logic [DATA_W-1:0] reg1,
    output logic [DATA_W-1:0] reg2,
    output logic              busy1,
    output logic              busy2,
    output logic              clr_busy
);

    typedef enum logic [0:0] {S_IDLE, S_CLEAR} state_t;

    localparam logic [ADDR_W:0]   REGS_LIM = (ADDR_W+1)'(NUM_REGS);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [NUM_REGS-1:0] pend_q, pend_d;
    logic                wr0_ok, wr1_ok, iss_ok;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < REGS_LIM;
    endfunction

    // ---------------- clear FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // ---------------- clear FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            S_IDLE: begin
                if (clr_req) begin
                    state_d = S_CLEAR;
                    idx_d   = '0;
                end
            end
            S_CLEAR: begin
                idx_d = idx_q + ADDR_W'(1);
                if (idx_q == LAST_IDX) begin
                    state_d = S_IDLE;
                    idx_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- clear FSM: outputs ----------------
    always_comb begin
        clr_busy = (state_q == S_CLEAR);
    end

    // Accepted-write qualifiers; port 1 drops out on a same-index collision
    // so port 0 wins both in the array and in the scoreboard.
    always_comb begin
        wr0_ok = writeBackEn && !clr_busy && in_range(Dest_wb);
        wr1_ok = wr2_en && !clr_busy && in_range(wr2_addr) &&
                 !(wr0_ok && (wr2_addr == Dest_wb));
        iss_ok = issue_en && !clr_busy && in_range(issue_dest);
    end

    // ---------------- register array ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= DATA_W'(i);
            end
        end else if (clr_busy) begin
            regs_q[idx_q] <= '0;
        end else begin
            if (wr1_ok) regs_q[wr2_addr] <= wr2_data;
            if (wr0_ok) regs_q[Dest_wb]  <= Result_WB;
        end
    end

    // ---------------- scoreboard ----------------
    // Issue is applied after the write clears, so a same-index set wins.
    always_comb begin
        pend_d = pend_q;
        if (clr_busy) begin
            pend_d[idx_q] = 1'b0;
        end else begin
            if (wr0_ok) pend_d[Dest_wb]    = 1'b0;
            if (wr1_ok) pend_d[wr2_addr]   = 1'b0;
            if (iss_ok) pend_d[issue_dest] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) pend_q <= '0;
        else     pend_q <= pend_d;
    end

    // ---------------- read ports ----------------
    always_comb begin
        reg1  = in_range(src1) ? regs_q[src1] : '0;
        reg2  = in_range(src2) ? regs_q[src2] : '0;
        busy1 = in_range(src1) && pend_q[src1];
        busy2 = in_range(src2) && pend_q[src2];
`ifdef RF_WB_BYPASS_EN
        if (wr0_ok && (Dest_wb == src1)) begin
            reg1  = Result_WB;
            busy1 = 1'b0;
        end else if (wr1_ok && (wr2_addr == src1)) begin
            reg1  = wr2_data;
            busy1 = 1'b0;
        end
        if (wr0_ok && (Dest_wb == src2)) begin
            reg2  = Result_WB;
            busy2 = 1'b0;
        end else if (wr1_ok && (wr2_addr == src2)) begin
            reg2  = wr2_data;
            busy2 = 1'b0;
        end
`endif
    end

endmodule

// File: doc/arm_regfile_sb.md
Name: arm_regfile_sb

Overview:
- Parametrised successor to the ARM pipeline register file.
- Provides:
  - two combinational read ports;
  - two write ports: the write-back result, plus a secondary port for base-register updates;
  - a per-register pending-write scoreboard for the hazard unit;
  - a sequenced clear engine.
- Sits between ID (reads, issue marking) and WB (writes).

Parameters:
- DATA_W, 32, register width in bits.
- NUM_REGS, 16, number of architectural registers.
- ADDR_W, 4, register index width; must satisfy 2**ADDR_W >= NUM_REGS.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- src1  in  ADDR_W  read port 1 index.
- src2  in  ADDR_W  read port 2 index.
- writeBackEn  in  1  write port 0 enable.
- Dest_wb  in  ADDR_W  write port 0 index.
- Result_WB  in  DATA_W  write port 0 data.
- wr2_en  in  1  write port 1 enable (base update).
- wr2_addr  in  ADDR_W  write port 1 index.
- wr2_data  in  DATA_W  write port 1 data.
- issue_en  in  1  mark issue_dest as pending.
- issue_dest  in  ADDR_W  register awaiting a result.
- clr_req  in  1  start the clear sequence.
- reg1  out  DATA_W  read data for src1.
- reg2  out  DATA_W  read data for src2.
- busy1  out  1  pending bit of src1.
- busy2  out  1  pending bit of src2.
- clr_busy  out  1  clear sequence in progress.

Behaviour:
- Reset (async, immediate):
  - register i <= i, zero-extended or truncated to DATA_W;
  - all pending bits = 0;
  - FSM = IDLE, clear index = 0, clr_busy = 0.
  - reg1/reg2 are combinational, so they show the src index value; busy1/busy2 = 0.
- Reads: combinational, zero latency. Any index >= NUM_REGS reads data 0 and busy 0.
- Writes:
  - Each enabled write updates the array at posedge.
  - Writes to index >= NUM_REGS are ignored.
  - Both ports targeting the same index in the same cycle: port 0 (Result_WB) wins; port 1 is dropped.
- Scoreboard:
  - issue_en sets pending[issue_dest] at posedge.
  - Any accepted write to index k clears pending[k].
  - Issue and write to the same index in the same cycle: set wins, pending stays 1.
- Clear FSM, IDLE:
  - clr_req=1 -> CLEAR, idx=0, clr_busy=1 from the next cycle.
- Clear FSM, CLEAR:
  - Each cycle writes register idx <= 0, clears pending[idx], and increments idx.
  - When idx = NUM_REGS-1 is written, go to IDLE and deassert clr_busy in the same edge.
  - Duration is exactly NUM_REGS cycles.
  - clr_req is ignored while in CLEAR; a clr_req held high re-triggers once back in IDLE.
  - Both write ports and issue_en are ignored while clr_busy=1.
  - Reads remain live and return current array contents, partly cleared.
- Reset mid-CLEAR: abort immediately; reset values apply.

Optional Feature:
- Macro RF_WB_BYPASS_EN.
- Defined:
  - A read whose index matches an enabled, accepted write in the same cycle returns the write data combinationally. Port 0 data takes priority over port 1.
  - busy1/busy2 are forced to 0 for that match.
  - Gives same-cycle visibility equivalent to a negedge-write file.
- Undefined: reads return array contents only; a write is visible from the cycle after its posedge.

Test Plan:
- Reset, then src1=5, src2=15 -> reg1=5, reg2=15, busy1=busy2=0, clr_busy=0.
- writeBackEn=1, Dest_wb=3, Result_WB=0xDEADBEEF, with wr2_en=1, wr2_addr=3, wr2_data=0x1 -> after the edge, src1=3 reads 0xDEADBEEF.
- issue_en=1 on issue_dest=7 -> busy on 7 = 1. Next cycle: issue 7 and write 7 together -> busy stays 1. Write 7 alone -> busy 0.
- Write 0xAAAA5555 to R2 with src1=2 in the same cycle:
  - RF_WB_BYPASS_EN defined -> reg1=0xAAAA5555 that cycle;
  - undefined -> reg1=2, then 0xAAAA5555 next cycle.
- clr_req pulse -> clr_busy high for exactly 16 cycles.
  - Writes to R9 attempted during CLEAR are ignored.
  - At the end, all registers read 0 and all busy bits are 0.
- Assert rst at the 6th CLEAR cycle -> clr_busy=0 immediately, R4 reads 4, R12 reads 12.
